// File: rtl/side_buffer_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : side_buffer_fifo_pkg
//  Brief    : Shared flit geometry and redirect state encodings for the
//             MinBD side buffer.
//  Revision : 1.0  initial release
// ============================================================================
package side_buffer_fifo_pkg;

    localparam int FLIT_W       = 11;
    localparam int NPORTS       = 5;
    localparam int SEL_W        = 3;
    localparam int DEPTH        = 4;
    localparam int REDIR_THRESH = 8;

    // Flit layout: MSB is the valid bit, the rest is opaque payload.
    localparam int VALID_BIT    = FLIT_W - 1;
    localparam int PAYLOAD_LSB  = 0;
    localparam int PAYLOAD_W    = FLIT_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STARVE = 2'd1,
        ST_REDIR  = 2'd2
    } redir_state_t;

endpackage
`default_nettype wire

// File: rtl/side_buffer_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : side_buffer_fifo_if
//  Brief    : Router-to-side-buffer bundle: capture request, head flit,
//             re-injection handshake and status.
//  Revision : 1.0  initial release
// ============================================================================
interface side_buffer_fifo_if #(
    parameter int FLIT_W = 11,
    parameter int NPORTS = 5,
    parameter int SEL_W  = 3,
    parameter int DEPTH  = 4
);
    logic [NPORTS*FLIT_W-1:0]  in_flits;
    logic [SEL_W-1:0]          sel;
    logic                      buf_en;
    logic                      push_ready;
    logic [FLIT_W-1:0]         sb_flit;
    logic                      sb_valid;
    logic                      pop;
    logic [$clog2(DEPTH):0]    count;
    logic                      redirect;

    modport master (
        output in_flits, sel, buf_en, pop,
        input  push_ready, sb_flit, sb_valid, count, redirect
    );

    modport slave (
        input  in_flits, sel, buf_en, pop,
        output push_ready, sb_flit, sb_valid, count, redirect
    );

endinterface
`default_nettype wire

// File: rtl/side_buffer_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : sb_fifo_mem
//  Brief    : DEPTH x FLIT_W register array, one synchronous write port and
//             one asynchronous read port. Contents are never reset.
//  Revision : 1.0  initial release
// ============================================================================
module sb_fifo_mem #(
    parameter int FLIT_W = 11,
    parameter int DEPTH  = 4
) (
    input  wire logic                     clk,
    input  wire logic                     we,
    input  wire logic [$clog2(DEPTH)-1:0] waddr,
    input  wire logic [FLIT_W-1:0]        wdata,
    input  wire logic [$clog2(DEPTH)-1:0] raddr,
    output logic      [FLIT_W-1:0]        rdata
);

    logic [FLIT_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/side_buffer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : side_buffer_fifo
//  Brief    : DEPTH-entry FIFO of deflected flits with starvation-driven
//             redirect request for forced re-injection.
//  Revision : 1.0  initial release
// ============================================================================
module side_buffer_fifo #(
    parameter int FLIT_W       = side_buffer_fifo_pkg::FLIT_W,
    parameter int NPORTS       = side_buffer_fifo_pkg::NPORTS,
    parameter int SEL_W        = side_buffer_fifo_pkg::SEL_W,
    parameter int DEPTH        = side_buffer_fifo_pkg::DEPTH,
    parameter int REDIR_THRESH = side_buffer_fifo_pkg::REDIR_THRESH
) (
    input  wire logic          clk,
    input  wire logic          rst,
    side_buffer_fifo_if.slave  sb
);
    import side_buffer_fifo_pkg::*;

    localparam int                 PTR_W       = $clog2(DEPTH);
    localparam int                 CNT_W       = PTR_W + 1;
    localparam int                 NSEL        = 2 ** SEL_W;
    localparam logic [CNT_W-1:0]   FULL_CNT    = CNT_W'(DEPTH);
    localparam logic [SEL_W:0]     NPORTS_C    = (SEL_W + 1)'(NPORTS);
    localparam logic [7:0]         THRESH_LAST = 8'(REDIR_THRESH - 1);

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    redir_state_t       r_state;
    logic [7:0]         r_starve_cnt;
    logic               r_redirect;

    logic [FLIT_W-1:0]  w_port_flit [NSEL];
    logic [FLIT_W-1:0]  w_cand;
    logic [FLIT_W-1:0]  w_head;
    logic               w_sel_ok;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_push_ready;
    logic               w_starved;

    // Unused select codes map to an all-zero (invalid) flit so they never push.
    generate
        for (genvar p = 0; p < NSEL; p++) begin : g_port
            if (p < NPORTS) begin : g_live
                assign w_port_flit[p] = sb.in_flits[p*FLIT_W +: FLIT_W];
            end else begin : g_unused
                assign w_port_flit[p] = '0;
            end
        end
    endgenerate

    assign w_sel_ok     = ({1'b0, sb.sel} < NPORTS_C);
    assign w_cand       = w_port_flit[sb.sel];
    assign w_full       = (r_count == FULL_CNT);
    assign w_empty      = (r_count == '0);
    assign w_pop        = sb.pop & ~w_empty;
    assign w_push_ready = ~w_full | w_pop;
    assign w_push       = sb.buf_en & w_sel_ok & w_cand[FLIT_W-1] & w_push_ready;
    assign w_starved    = w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    sb_fifo_mem #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (w_cand),
        .raddr (r_rd_ptr),
        .rdata (w_head)
    );

    // Starvation watchdog: counts full cycles in which nothing drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            r_redirect   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_starved) begin
                        if (THRESH_LAST == 8'd0) begin
                            r_state    <= ST_REDIR;
                            r_redirect <= 1'b1;
                        end else begin
                            r_state <= ST_STARVE;
                        end
                        r_starve_cnt <= 8'd1;
                    end
                end
                ST_STARVE: begin
                    if (w_starved) begin
                        if (r_starve_cnt == THRESH_LAST) begin
                            r_state    <= ST_REDIR;
                            r_redirect <= 1'b1;
                        end
                        r_starve_cnt <= r_starve_cnt + 8'd1;
                    end else begin
                        r_state      <= ST_IDLE;
                        r_starve_cnt <= '0;
                    end
                end
                ST_REDIR: begin
                    if (w_pop) begin
                        r_state      <= ST_IDLE;
                        r_starve_cnt <= '0;
                        r_redirect   <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_starve_cnt <= '0;
                    r_redirect   <= 1'b0;
                end
            endcase
        end
    end

    assign sb.push_ready = w_push_ready;
    assign sb.sb_valid   = ~w_empty;
    assign sb.sb_flit    = w_empty ? '0 : w_head;
    assign sb.count      = r_count;
    assign sb.redirect   = r_redirect;

endmodule
`default_nettype wire

// File: tb/tb_side_buffer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_side_buffer_fifo
//  Brief    : Scoreboard bench for side_buffer_fifo (DEPTH=4, THRESH=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_side_buffer_fifo;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [10:0] exp_q [$];

    side_buffer_fifo_if #(.FLIT_W(11), .NPORTS(5), .SEL_W(3), .DEPTH(4)) sbif ();

    side_buffer_fifo #(
        .FLIT_W       (11),
        .NPORTS       (5),
        .SEL_W        (3),
        .DEPTH        (4),
        .REDIR_THRESH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted re-injection must match the oldest expected flit.
    always @(negedge clk) begin
        if (!rst && sbif.pop && sbif.sb_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_unexpected: got %0h expected none", sbif.sb_flit);
            end else begin
                chk("pop_flit", 32'(sbif.sb_flit), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive(input int port, input logic [10:0] f, input logic en, input logic p);
        logic [54:0] v;
        v = '0;
        if (port < 5) v[port*11 +: 11] = f;
        else          v = '1;
        sbif.in_flits = v;
        sbif.sel      = 3'(port);
        sbif.buf_en   = en;
        sbif.pop      = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sbif.in_flits = '0;
        sbif.sel      = '0;
        sbif.buf_en   = 1'b0;
        sbif.pop      = 1'b0;
    endtask

    task automatic push_exp(input int port, input logic [10:0] f);
        drive(port, f, 1'b1, 1'b0);
        exp_q.push_back(f);
        tick();
    endtask

    task automatic pop_one();
        drive(0, 11'h0, 1'b0, 1'b1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        sbif.in_flits = '0;
        sbif.sel      = '0;
        sbif.buf_en   = 1'b0;
        sbif.pop      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_count",      32'(sbif.count), 32'd0);
        chk("rst_valid",      32'(sbif.sb_valid), 32'd0);
        chk("rst_flit",       32'(sbif.sb_flit), 32'd0);
        chk("rst_push_ready", 32'(sbif.push_ready), 32'd1);
        chk("rst_redirect",   32'(sbif.redirect), 32'd0);

        // Single push through port 2
        push_exp(2, 11'h4A5);
        chk("t1_valid", 32'(sbif.sb_valid), 32'd1);
        chk("t1_flit",  32'(sbif.sb_flit), 32'h4A5);
        chk("t1_count", 32'(sbif.count), 32'd1);
        pop_one();
        chk("t1_count_after_pop", 32'(sbif.count), 32'd0);
        chk("t1_flit_after_pop",  32'(sbif.sb_flit), 32'd0);

        // Dropped pushes and pop on empty
        drive(6, 11'h7FF, 1'b1, 1'b0);
        tick();
        chk("t5_sel_oor", 32'(sbif.count), 32'd0);
        drive(2, 11'h0FF, 1'b1, 1'b0);
        tick();
        chk("t5_invalid_flit", 32'(sbif.count), 32'd0);
        pop_one();
        chk("t5_pop_empty_count", 32'(sbif.count), 32'd0);
        chk("t5_pop_empty_valid", 32'(sbif.sb_valid), 32'd0);

        // Fill to DEPTH, overflow push dropped, drain in order
        push_exp(0, 11'h401);
        push_exp(1, 11'h412);
        push_exp(3, 11'h423);
        push_exp(4, 11'h434);
        chk("t2_count_full", 32'(sbif.count), 32'd4);
        drive(0, 11'h455, 1'b1, 1'b0);
        #1;
        chk("t2_push_ready_full", 32'(sbif.push_ready), 32'd0);
        tick();
        chk("t2_count_after_drop", 32'(sbif.count), 32'd4);
        chk("t2_head", 32'(sbif.sb_flit), 32'h401);
        repeat (4) pop_one();
        chk("t2_flit_empty",  32'(sbif.sb_flit), 32'd0);
        chk("t2_valid_empty", 32'(sbif.sb_valid), 32'd0);
        chk("t2_queue_drained", 32'(exp_q.size()), 32'd0);

        // Simultaneous push and pop while full
        push_exp(0, 11'h401);
        push_exp(1, 11'h412);
        push_exp(3, 11'h423);
        push_exp(4, 11'h434);
        drive(1, 11'h5E5, 1'b1, 1'b1);
        #1;
        chk("t3_push_ready_pop", 32'(sbif.push_ready), 32'd1);
        exp_q.push_back(11'h5E5);
        tick();
        chk("t3_count", 32'(sbif.count), 32'd4);
        chk("t3_head",  32'(sbif.sb_flit), 32'h412);

        // Starvation for THRESH cycles raises redirect
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) chk("t4_redirect_early", 32'(sbif.redirect), 32'd0);
            if (i == 8) chk("t4_redirect_set",   32'(sbif.redirect), 32'd1);
        end
        pop_one();
        chk("t4_redirect_clear", 32'(sbif.redirect), 32'd0);
        chk("t4_count", 32'(sbif.count), 32'd3);
        repeat (3) pop_one();
        chk("t3_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("t3_count_empty", 32'(sbif.count), 32'd0);

        // Reset while full and redirecting, with push and pop requested
        push_exp(0, 11'h460);
        push_exp(1, 11'h471);
        push_exp(2, 11'h482);
        push_exp(3, 11'h493);
        repeat (8) tick();
        chk("t6_redirect_pre", 32'(sbif.redirect), 32'd1);
        rst = 1'b1;
        drive(0, 11'h5AA, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("t6_count",      32'(sbif.count), 32'd0);
        chk("t6_valid",      32'(sbif.sb_valid), 32'd0);
        chk("t6_redirect",   32'(sbif.redirect), 32'd0);
        chk("t6_flit",       32'(sbif.sb_flit), 32'd0);
        chk("t6_push_ready", 32'(sbif.push_ready), 32'd1);

        // Normal operation resumes after reset
        push_exp(4, 11'h7FF);
        chk("t6_post_flit", 32'(sbif.sb_flit), 32'h7FF);
        pop_one();
        chk("t6_post_count", 32'(sbif.count), 32'd0);
        chk("t6_post_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
